// File: rtl/uart_pkg.sv
// Shared constants for uart_fifo_core: register indices, CFG/STAT bit positions,
// parity encodings and the RX/TX FSM state codes.
package uart_pkg;

  localparam logic [1:0] RegDiv  = 2'd0;
  localparam logic [1:0] RegData = 2'd1;
  localparam logic [1:0] RegCfg  = 2'd2;
  localparam logic [1:0] RegStat = 2'd3;

  localparam int unsigned CfgEn    = 0;
  localparam int unsigned CfgStop2 = 1;
  localparam int unsigned CfgParLo = 2;
  localparam int unsigned CfgParHi = 3;
  localparam int unsigned CfgRxie  = 4;
  localparam int unsigned CfgTxie  = 5;

  localparam int unsigned StatRxNe   = 0;
  localparam int unsigned StatTxFull = 1;
  localparam int unsigned StatOvr    = 2;
  localparam int unsigned StatFerr   = 3;
  localparam int unsigned StatPerr   = 4;
  localparam int unsigned StatTxIdle = 5;

  localparam logic [1:0] ParNone = 2'b00;
  localparam logic [1:0] ParEven = 2'b01;
  localparam logic [1:0] ParOdd  = 2'b10;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  function automatic logic par_active(input logic [1:0] par);
    return (par == ParEven) || (par == ParOdd);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy level; a push into a full FIFO succeeds only
// when a pop happens in the same cycle, a pop from an empty FIFO is ignored.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned LvlW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LvlW-1:0]  level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == LvlW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + LvlW'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with RX/TX FIFOs, sticky error flags and level interrupt.
// Optional parity support is compiled in when UART_PARITY_EN is defined.
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_RESET  = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        reg_valid,
  input  logic        reg_we,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_ready,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic        enabled,
  output logic        irq
);

  localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);
`ifdef UART_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic [DIV_WIDTH-1:0] div_q, div_d, div_eff, start_pt;
  logic [5:0]           cfg_q, cfg_d;
  logic                 ovr_q, ovr_d, ferr_q, ferr_d, perr_q, perr_d;
  logic                 ovr_set, ferr_set, perr_set;
  logic                 wr_en, rd_en, wr_stat, par_on, par_odd;
  logic                 tx_push, tx_pop, tx_full, tx_empty, tx_idle;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]           tx_rdata, rx_rdata;
  logic [LvlW-1:0]      tx_level, rx_level;
  logic [31:0]          stat;
  logic                 unused_wdata;

  assign unused_wdata = ^reg_wdata;

  assign div_eff  = (div_q < DIV_WIDTH'(3)) ? DIV_WIDTH'(3) : div_q;
  assign start_pt = (div_eff - DIV_WIDTH'(1)) >> 1;
  assign par_on   = ParEn & par_active(cfg_q[CfgParHi:CfgParLo]);
  assign par_odd  = (cfg_q[CfgParHi:CfgParLo] == ParOdd);

  // Register port
  assign wr_en     = reg_valid & reg_we;
  assign rd_en     = reg_valid & ~reg_we;
  assign wr_stat   = wr_en & (reg_addr == RegStat);
  assign tx_push   = wr_en & (reg_addr == RegData) & (~tx_full | tx_pop);
  assign reg_ready = ~(wr_en & (reg_addr == RegData) & tx_full & ~tx_pop);
  assign rx_pop    = rd_en & (reg_addr == RegData) & ~rx_empty;
  assign enabled   = cfg_q[CfgEn];

  always_comb begin
    div_d = div_q;
    cfg_d = cfg_q;
    if (wr_en && reg_addr == RegDiv) begin
      div_d = reg_wdata[DIV_WIDTH-1:0];
    end
    if (wr_en && reg_addr == RegCfg) begin
      cfg_d = reg_wdata[5:0];
      if (!ParEn) cfg_d[CfgParHi:CfgParLo] = ParNone;
    end
    // A same-cycle set wins over a W1C clear so no event is lost.
    ovr_d  = (ovr_q  & ~(wr_stat & reg_wdata[StatOvr]))  | ovr_set;
    ferr_d = (ferr_q & ~(wr_stat & reg_wdata[StatFerr])) | ferr_set;
    perr_d = (perr_q & ~(wr_stat & reg_wdata[StatPerr])) | perr_set;
  end

  assign stat = {8'h00, 8'(tx_level), 8'(rx_level), 2'b00, tx_idle, perr_q, ferr_q, ovr_q,
                 tx_full, ~rx_empty};

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      RegDiv:  reg_rdata = 32'(div_q);
      RegData: reg_rdata = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_rdata};
      RegCfg:  reg_rdata = {26'h0, cfg_q};
      RegStat: reg_rdata = stat;
      default: reg_rdata = '0;
    endcase
  end

  assign irq = (cfg_q[CfgRxie] & ~rx_empty) | (cfg_q[CfgTxie] & tx_empty) |
               ovr_q | ferr_q | perr_q;

  // TX engine
  logic [2:0]           tx_state_q, tx_state_d, tx_bit_q, tx_bit_d;
  logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]           tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d, tx_par_en_q, tx_par_en_d;
  logic                 tx_stop_q, tx_stop_d, tx_out_q, tx_out_d, tx_tick;

  assign tx_tick = (tx_cnt_q >= div_eff);
  assign tx_idle = tx_empty & (tx_state_q == StIdle);
  assign ser_tx  = tx_out_q;

  always_comb begin
    tx_pop      = 1'b0;
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_tick ? '0 : tx_cnt_q + DIV_WIDTH'(1);
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_par_d    = tx_par_q;
    tx_par_en_d = tx_par_en_q;
    tx_stop_d   = tx_stop_q;
    tx_out_d    = tx_out_q;
    case (tx_state_q)
      StIdle: begin
        tx_cnt_d = '0;
        tx_out_d = 1'b1;
        if (cfg_q[CfgEn] && !tx_empty) begin
          tx_pop      = 1'b1;
          tx_state_d  = StStart;
          tx_shift_d  = tx_rdata;
          tx_par_en_d = par_on;
          tx_par_d    = (^tx_rdata) ^ par_odd;
          tx_out_d    = 1'b0;
        end
      end
      StStart: if (tx_tick) begin
        tx_state_d = StData;
        tx_bit_d   = '0;
        tx_out_d   = tx_shift_q[0];
      end
      StData: if (tx_tick) begin
        if (tx_bit_q == 3'd7) begin
          tx_state_d = tx_par_en_q ? StParity : StStop;
          tx_out_d   = tx_par_en_q ? tx_par_q : 1'b1;
          tx_stop_d  = 1'b0;
        end else begin
          tx_shift_d = tx_shift_q >> 1;
          tx_out_d   = tx_shift_q[1];
          tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      StParity: if (tx_tick) begin
        tx_state_d = StStop;
        tx_stop_d  = 1'b0;
        tx_out_d   = 1'b1;
      end
      StStop: if (tx_tick) begin
        if (cfg_q[CfgStop2] && !tx_stop_q) tx_stop_d = 1'b1;
        else                               tx_state_d = StIdle;
      end
      default: begin
        tx_state_d = StIdle;
        tx_out_d   = 1'b1;
      end
    endcase
  end

  // RX engine
  logic                 rx_s1_q, rx_in;
  logic [2:0]           rx_state_q, rx_state_d, rx_bit_q, rx_bit_d;
  logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]           rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d, rx_par_en_q, rx_par_en_d, rx_odd_q, rx_odd_d;
  logic                 rx_tick;

  assign rx_tick = (rx_cnt_q >= div_eff);
  assign ovr_set = rx_push & rx_full & ~rx_pop;

  always_comb begin
    rx_push     = 1'b0;
    ferr_set    = 1'b0;
    perr_set    = 1'b0;
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + DIV_WIDTH'(1);
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_par_d    = rx_par_q;
    rx_par_en_d = rx_par_en_q;
    rx_odd_d    = rx_odd_q;
    if (!cfg_q[CfgEn]) begin
      rx_state_d = StIdle;
      rx_cnt_d   = '0;
    end else begin
      case (rx_state_q)
        StIdle: begin
          rx_cnt_d = '0;
          if (!rx_in) rx_state_d = StStart;
        end
        StStart: if (rx_cnt_q >= start_pt) begin
          rx_cnt_d    = '0;
          rx_bit_d    = '0;
          rx_par_en_d = par_on;
          rx_odd_d    = par_odd;
          rx_state_d  = rx_in ? StIdle : StData;
        end
        StData: if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_in, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = rx_par_en_q ? StParity : StStop;
        end
        StParity: if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_in;
          rx_state_d = StStop;
        end
        StStop: if (rx_tick) begin
          rx_state_d = StIdle;
          if (!rx_in) begin
            ferr_set = 1'b1;
          end else if (rx_par_en_q && ((^rx_shift_q) ^ rx_par_q ^ rx_odd_q)) begin
            perr_set = 1'b1;
          end else begin
            rx_push = 1'b1;
          end
        end
        default: rx_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q       <= DIV_WIDTH'(DIV_RESET);
      cfg_q       <= '0;
      ovr_q       <= 1'b0;
      ferr_q      <= 1'b0;
      perr_q      <= 1'b0;
      tx_state_q  <= StIdle;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_par_q    <= 1'b0;
      tx_par_en_q <= 1'b0;
      tx_stop_q   <= 1'b0;
      tx_out_q    <= 1'b1;
      rx_s1_q     <= 1'b1;
      rx_in       <= 1'b1;
      rx_state_q  <= StIdle;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_par_q    <= 1'b0;
      rx_par_en_q <= 1'b0;
      rx_odd_q    <= 1'b0;
    end else begin
      div_q       <= div_d;
      cfg_q       <= cfg_d;
      ovr_q       <= ovr_d;
      ferr_q      <= ferr_d;
      perr_q      <= perr_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_par_q    <= tx_par_d;
      tx_par_en_q <= tx_par_en_d;
      tx_stop_q   <= tx_stop_d;
      tx_out_q    <= tx_out_d;
      rx_s1_q     <= ser_rx;
      rx_in       <= rx_s1_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_par_q    <= rx_par_d;
      rx_par_en_q <= rx_par_en_d;
      rx_odd_q    <= rx_odd_d;
    end
  end

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (tx_push),
    .wdata  (reg_wdata[7:0]),
    .pop    (tx_pop),
    .rdata  (tx_rdata),
    .full   (tx_full),
    .empty  (tx_empty),
    .level  (tx_level)
  );

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (rx_push),
    .wdata  (rx_shift_q),
    .pop    (rx_pop),
    .rdata  (rx_rdata),
    .full   (rx_full),
    .empty  (rx_empty),
    .level  (rx_level)
  );

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed self-checking bench for uart_fifo_core (DIV=9, FIFO_DEPTH=8).
module tb_uart_fifo_core;

  localparam logic [1:0] ADiv  = 2'd0;
  localparam logic [1:0] AData = 2'd1;
  localparam logic [1:0] ACfg  = 2'd2;
  localparam logic [1:0] AStat = 2'd3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        reg_valid, reg_we, reg_ready;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        ser_rx, ser_tx, enabled, irq;
  int          checks = 0;
  int          errors = 0;

  uart_fifo_core #(
    .DIV_WIDTH  (16),
    .FIFO_DEPTH (8),
    .DIV_RESET  (1)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .reg_valid (reg_valid),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_ready (reg_ready),
    .ser_rx    (ser_rx),
    .ser_tx    (ser_tx),
    .enabled   (enabled),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int stall);
    @(negedge clk);
    reg_valid = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    #1;
    stall = 0;
    while (!reg_ready && stall < 2000) begin
      @(negedge clk); #1; stall++;
    end
    if (!reg_ready) begin
      checks++; errors++;
      $display("FAIL write_timeout: addr %0d ready %b, required 1", a, reg_ready);
    end
    @(posedge clk); #1;
    reg_valid = 1'b0; reg_we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    int s;
    bus_write(a, d, s);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    reg_valid = 1'b1; reg_we = 1'b0; reg_addr = a;
    #1 d = reg_rdata;
    @(posedge clk); #1;
    reg_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input logic has_par,
                         input logic par);
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (10) @(negedge clk);
    end
    if (has_par) begin
      ser_rx = par;
      repeat (10) @(negedge clk);
    end
    ser_rx = stop;
    repeat (10) @(negedge clk);
    ser_rx = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic tx_capture(output logic [7:0] d, output logic ok);
    int n = 0;
    ok = 1'b1;
    d  = '0;
    while (ser_tx !== 1'b0 && n < 400) begin
      @(negedge clk); n++;
    end
    if (ser_tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (5) @(negedge clk);
    if (ser_tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(negedge clk);
      d[i] = ser_tx;
    end
    repeat (10) @(negedge clk);
    if (ser_tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    resetn = 1'b0; reg_valid = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
    ser_rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if (ser_tx !== 1'b1) begin errors++; $display("FAIL reset_ser_tx: got %b, required 1", ser_tx); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b, required 0", irq); end
    checks++;
    if (enabled !== 1'b0) begin errors++; $display("FAIL reset_enabled: got %b, required 0", enabled); end
    rd(ADiv, r);
    checks++;
    if (r !== 32'd1) begin errors++; $display("FAIL reset_div: got %h, required 1", r); end
    rd(ACfg, r);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL reset_cfg: got %h, required 0", r); end
    rd(AStat, r);
    checks++;
    if (r !== 32'h20) begin errors++; $display("FAIL reset_stat: got %h, required 20", r); end
    rd(AData, r);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_data: got %h, required ffffffff", r); end
  endtask

  task automatic test_tx_basic;
    logic [7:0]  got;
    logic [31:0] r;
    int          n = 0;
    int          lo = 0;
    wr(ADiv, 32'd9);
    wr(ACfg, 32'h1);
    checks++;
    if (enabled !== 1'b1) begin errors++; $display("FAIL tx_enabled: got %b, required 1", enabled); end
    wr(AData, 32'h55);
    while (ser_tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    while (ser_tx === 1'b0 && lo < 30) begin lo++; @(negedge clk); end
    checks++;
    if (lo != 10) begin errors++; $display("FAIL tx_start_len: got %0d clocks, required 10", lo); end
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      got[i] = ser_tx;
      repeat (10) @(negedge clk);
    end
    checks++;
    if (got !== 8'h55) begin errors++; $display("FAIL tx_data: got %h, required 55", got); end
    checks++;
    if (ser_tx !== 1'b1) begin errors++; $display("FAIL tx_stop: got %b, required 1", ser_tx); end
    repeat (10) @(negedge clk);
    rd(AStat, r);
    checks++;
    if (r !== 32'h20) begin errors++; $display("FAIL tx_idle_stat: got %h, required 20", r); end
  endtask

  task automatic test_tx_burst;
    logic [7:0]  exp_b [10] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A,
                                8'hA5, 8'hFF, 8'h00, 8'h81, 8'h7E};
    logic [31:0] r;
    fork
      begin
        int stall;
        wr(AData, 32'(exp_b[0]));
        repeat (3) @(negedge clk);
        for (int i = 1; i < 9; i++) wr(AData, 32'(exp_b[i]));
        rd(AStat, r);
        checks++;
        if ((r & 32'h00FF_0002) !== 32'h0008_0002) begin
          errors++; $display("FAIL burst_full_stat: got %h, required tx level 8 and full", r);
        end
        bus_write(AData, 32'(exp_b[9]), stall);
        checks++;
        if (stall < 50) begin
          errors++; $display("FAIL burst_stall: got %0d stall clocks, required >= 50", stall);
        end
      end
      begin
        logic [7:0] d;
        logic       ok;
        for (int i = 0; i < 10; i++) begin
          tx_capture(d, ok);
          checks++;
          if (!ok || d !== exp_b[i]) begin
            errors++;
            $display("FAIL burst_frame%0d: got %h (framing ok %b), required %h", i, d, ok, exp_b[i]);
          end
        end
      end
    join
    repeat (20) @(negedge clk);
    rd(AStat, r);
    checks++;
    if (r !== 32'h20) begin errors++; $display("FAIL burst_end_stat: got %h, required 20", r); end
  endtask

  task automatic test_rx_overrun;
    logic [31:0] r;
    for (int i = 1; i <= 9; i++) send_rx(8'(i), 1'b1, 1'b0, 1'b0);
    rd(AStat, r);
    checks++;
    if (r !== 32'h0000_0825) begin errors++; $display("FAIL ovr_stat: got %h, required 00000825", r); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL ovr_irq: got %b, required 1", irq); end
    for (int i = 1; i <= 8; i++) begin
      rd(AData, r);
      checks++;
      if (r !== 32'(i)) begin errors++; $display("FAIL ovr_read%0d: got %h, required %h", i, r, i); end
    end
    rd(AData, r);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ovr_empty: got %h, required ffffffff", r); end
    wr(AStat, 32'h4);
    rd(AStat, r);
    checks++;
    if (r !== 32'h20) begin errors++; $display("FAIL ovr_clear: got %h, required 20", r); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ovr_irq_clear: got %b, required 0", irq); end
  endtask

  task automatic test_rx_errors;
    logic [31:0] r;
    send_rx(8'hC3, 1'b0, 1'b0, 1'b0);
    rd(AStat, r);
    checks++;
    if (r !== 32'h28) begin errors++; $display("FAIL ferr_stat: got %h, required 28", r); end
    rd(AData, r);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ferr_nopush: got %h, required ffffffff", r); end
    wr(AStat, 32'h8);
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (3) @(negedge clk);
    ser_rx = 1'b1;
    repeat (30) @(negedge clk);
    rd(AStat, r);
    checks++;
    if (r !== 32'h20) begin errors++; $display("FAIL glitch_stat: got %h, required 20", r); end
    send_rx(8'h5A, 1'b1, 1'b0, 1'b0);
    rd(AData, r);
    checks++;
    if (r !== 32'h5A) begin errors++; $display("FAIL glitch_recover: got %h, required 5a", r); end
  endtask

  task automatic test_parity;
    logic [31:0] r;
`ifdef UART_PARITY_EN
    wr(ACfg, 32'h05);
    rd(ACfg, r);
    checks++;
    if (r !== 32'h05) begin errors++; $display("FAIL par_cfg: got %h, required 05", r); end
    send_rx(8'h03, 1'b1, 1'b1, 1'b1);
    rd(AStat, r);
    checks++;
    if (r !== 32'h30) begin errors++; $display("FAIL perr_stat: got %h, required 30", r); end
    rd(AData, r);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL perr_nopush: got %h, required ffffffff", r); end
    wr(AStat, 32'h10);
    send_rx(8'h03, 1'b1, 1'b1, 1'b0);
    rd(AData, r);
    checks++;
    if (r !== 32'h03) begin errors++; $display("FAIL par_good: got %h, required 03", r); end
`else
    wr(ACfg, 32'h0D);
    rd(ACfg, r);
    checks++;
    if (r !== 32'h01) begin errors++; $display("FAIL nopar_cfg: got %h, required 01", r); end
    send_rx(8'h03, 1'b1, 1'b0, 1'b0);
    rd(AData, r);
    checks++;
    if (r !== 32'h03) begin errors++; $display("FAIL nopar_rx: got %h, required 03", r); end
`endif
    rd(AStat, r);
    checks++;
    if (r !== 32'h20) begin errors++; $display("FAIL par_end_stat: got %h, required 20", r); end
    wr(ACfg, 32'h01);
  endtask

  task automatic test_irq;
    logic [31:0] r;
    wr(ACfg, 32'h21);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_txie: got %b, required 1", irq); end
    wr(ACfg, 32'h11);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_rxie_empty: got %b, required 0", irq); end
    send_rx(8'h42, 1'b1, 1'b0, 1'b0);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_rxie_data: got %b, required 1", irq); end
    rd(AData, r);
    checks++;
    if (r !== 32'h42 || irq !== 1'b0) begin
      errors++; $display("FAIL irq_rx_drain: got data %h irq %b, required 42 and 0", r, irq);
    end
    wr(ACfg, 32'h01);
  endtask

  task automatic test_reset_mid_tx;
    logic [31:0] r;
    wr(AData, 32'h00);
    repeat (30) @(negedge clk);
    checks++;
    if (ser_tx !== 1'b0) begin errors++; $display("FAIL midtx_busy: got %b, required 0", ser_tx); end
    resetn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ser_tx !== 1'b1) begin errors++; $display("FAIL midtx_reset_tx: got %b, required 1", ser_tx); end
    @(negedge clk);
    resetn = 1'b1;
    rd(AStat, r);
    checks++;
    if (r !== 32'h20) begin errors++; $display("FAIL midtx_stat: got %h, required 20", r); end
    rd(ADiv, r);
    checks++;
    if (r !== 32'd1 || enabled !== 1'b0) begin
      errors++; $display("FAIL midtx_regs: got div %h en %b, required 1 and 0", r, enabled);
    end
  endtask

  initial begin
    test_reset;
    test_tx_basic;
    test_tx_burst;
    test_rx_overrun;
    test_rx_errors;
    test_parity;
    test_irq;
    test_reset_mid_tx;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
